// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying a control word and a datapath word between pipeline stages.
// master drives valid/ctrl/data and samples ready; slave does the reverse.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 138
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked inter-stage pipeline register with 2-entry skid buffer and synchronous flush.
// Optional perf counters (stall/flush) are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 138,
  parameter int CTRL_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  output logic [1:0]       occupancy_o,
  output logic [15:0]      stall_cnt_o,
  output logic [7:0]       flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              accept;
  logic              drain;

  // in_ready comes straight from state; flush is the only combinational term.
  assign in_if.ready = (state_q != TWO) & ~flush_i;
  assign accept      = in_if.valid & in_if.ready;
  assign drain       = out_valid_q & out_if.ready;

  // NOTE: synchronous reset and non-blocking assignments only; the skid entry is cleared too so
  // every flop has a defined value after reset, even though its contents are don't-care when empty.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= ONE;
            out_valid_q <= 1'b1;
            main_ctrl_q <= in_if.ctrl;
            main_data_q <= in_if.data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_ctrl_q <= in_if.ctrl;
            main_data_q <= in_if.data;
          end else if (accept) begin
            state_q     <= TWO;
            skid_ctrl_q <= in_if.ctrl;
            skid_data_q <= in_if.data;
          end else if (drain) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
          end
        end
        TWO: begin
          if (drain) begin
            state_q     <= ONE;
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          main_ctrl_q <= '0;
          main_data_q <= '0;
        end
      endcase
    end
  end

  // Main entry is zeroed on every path to EMPTY, so a bubble already carries NOP control.
  assign out_if.valid = out_valid_q;
  assign out_if.ctrl  = main_ctrl_q;
  assign out_if.data  = main_data_q;
  assign occupancy_o  = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_if.ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_i && state_q != EMPTY && flush_cnt_q != 8'hFF)
      flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table-driven vectors against a queue scoreboard,
// plus hand sequences for perf counters (expectations follow PIPE_STAGE_PERF_EN).
module tb_pipe_stage_reg;
  localparam int DW = 138;
  localparam int CW = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_if ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_if ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (flush),
    .in_if       (in_if),
    .out_if      (out_if),
    .occupancy_o (occupancy),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    logic          rst;
    logic          fl;
    logic          iv;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          ordy;
    logic          exp_rdy;
    logic [1:0]    exp_occ;
  } vec_t;

  entry_t      sb_q[$];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
  logic        perf_en;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                              input logic [CW-1:0] ctrl, input logic [DW-1:0] data,
                              input logic ordy, input logic exp_rdy, input logic [1:0] exp_occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ctrl = ctrl; v.data = data;
    v.ordy = ordy; v.exp_rdy = exp_rdy; v.exp_occ = exp_occ;
    return v;
  endfunction

  // One clock: drive, check against scoreboard, advance the scoreboard across the edge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy,
                       input logic chk_tab, input logic tab_rdy, input logic [1:0] tab_occ);
    entry_t head;
    logic   exp_rdy;
    logic   drain_m;
    logic   accept_m;
    reset = rst; flush = fl; in_if.valid = iv; in_if.ctrl = ic; in_if.data = id;
    out_if.ready = ordy;
    #1;
    head    = (sb_q.size() != 0) ? sb_q[0] : '0;
    exp_rdy = (sb_q.size() != 2) && !fl;
    check("in_ready", in_if.ready, exp_rdy);
    check("out_valid", out_if.valid, sb_q.size() != 0);
    check("out_ctrl", out_if.ctrl, head.ctrl);
    check("out_data", out_if.data, head.data);
    check("occupancy", occupancy, sb_q.size());
    check("stall_cnt", stall_cnt, exp_stall);
    check("flush_cnt", flush_cnt, exp_flush);
    if (chk_tab) check("tab_in_ready", in_if.ready, tab_rdy);
    drain_m  = (sb_q.size() != 0) && ordy;
    accept_m = iv && exp_rdy;
    if (rst) begin
      sb_q.delete();
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (perf_en) begin
        if (sb_q.size() != 0 && !ordy && exp_stall < 32'hFFFF) exp_stall++;
        if (fl && sb_q.size() != 0 && exp_flush < 32'hFF) exp_flush++;
      end
      if (fl) sb_q.delete();
      else begin
        if (drain_m) void'(sb_q.pop_front());
        if (accept_m) sb_q.push_back({ic, id});
      end
    end
    @(posedge clock);
    #1;
    if (chk_tab) check("tab_occ_after", occupancy, tab_occ);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, ordy, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    cycle(1'b0, 1'b0, 1'b1, c, d, ordy, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
`ifdef PIPE_STAGE_PERF_EN
    perf_en = 1'b1;
`else
    perf_en = 1'b0;
`endif
    // Streaming: 8 back-to-back pushes with out_ready=1, then drain
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 0, 1, 10'h3FF, DW'(k), 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 0));
    // Bubble mid-stream
    vecs.push_back(mk(0, 0, 1, 10'h155, DW'(9), 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h2AA, DW'(10), 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 10'h001, DW'(11), 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h200, {2'b10, 136'h0, 2'b01}, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 0));
    // Backpressure: A,B held, C refused until space frees
    vecs.push_back(mk(0, 0, 1, 10'h0A1, DW'(16'hAAAA), 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h0B2, DW'(16'hBBBB), 0, 1, 2));
    vecs.push_back(mk(0, 0, 1, 10'h0C3, DW'(16'hCCCC), 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 10'h0C3, DW'(16'hCCCC), 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 10'h0C3, DW'(16'hCCCC), 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 10'h0C3, DW'(16'hCCCC), 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 0));
    // Flush with two held and a valid input offered
    vecs.push_back(mk(0, 0, 1, 10'h0D4, DW'(16'hDDDD), 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h0E5, DW'(16'hEEEE), 0, 1, 2));
    vecs.push_back(mk(0, 1, 1, 10'h0F6, DW'(16'hFFFF), 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 0));
    // Reset mid-transfer discards both entries
    vecs.push_back(mk(0, 0, 1, 10'h111, DW'(32'h1111), 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h122, DW'(32'h2222), 0, 1, 2));
    vecs.push_back(mk(1, 0, 1, 10'h133, DW'(32'h3333), 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 0));
    // Reset and flush together; flush with one held while draining and offering
    vecs.push_back(mk(0, 0, 1, 10'h144, DW'(32'h4444), 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 10'h155, DW'(32'h5555), 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h166, DW'(32'h6666), 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 10'h177, DW'(32'h7777), 1, 0, 0));
    // Skid -> main promotion while a new input waits
    vecs.push_back(mk(0, 0, 1, 10'h188, DW'(32'h8888), 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 10'h199, DW'(32'h9999), 0, 1, 2));
    vecs.push_back(mk(0, 0, 1, 10'h1AA, DW'(32'hAAAA), 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, '0, '0, 1, 1, 0));

    reset = 1'b1; flush = 1'b0; in_if.valid = 1'b0; in_if.ctrl = '0; in_if.data = '0;
    out_if.ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    foreach (vecs[i])
      cycle(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ctrl, vecs[i].data, vecs[i].ordy,
            1'b1, vecs[i].exp_rdy, vecs[i].exp_occ);

    // Perf: five stall cycles, then a flush with two held
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 2'd0);
    push(10'h3C3, DW'(1), 1'b0);
    push(10'h3C4, DW'(2), 1'b0);
    repeat (4) idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 2'd0);
    check("perf_stall_5", stall_cnt, perf_en ? 16'd5 : 16'd0);
    check("perf_flush_1", flush_cnt, perf_en ? 8'd1 : 8'd0);
    idle(1'b1);

    // Stall-counter saturation
    push(10'h3C5, DW'(3), 1'b0);
    if (perf_en) begin
      in_if.valid = 1'b0;
      out_if.ready = 1'b0;
      repeat (70000) @(posedge clock);
      #1;
      check("perf_stall_sat", stall_cnt, 16'hFFFF);
      exp_stall = 32'hFFFF;
      idle(1'b0);
    end else begin
      repeat (20) idle(1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
